// File: rtl/keccak_block_ring_in_pkg.sv
//------------------------------------------------------------------------------
// Module  : keccak_block_ring_in_pkg
// Brief   : Shared constants, slot state type and helpers for the input ring.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package keccak_block_ring_in_pkg;

  localparam int IN_BUF_SIZE = 64;
  localparam int KECCAK_RATE = 1024;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/keccak_block_ring_in_if.sv
//------------------------------------------------------------------------------
// Module  : keccak_block_ring_in_if
// Brief   : Word-in / block-out handshake bundle for the Keccak input ring.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface keccak_block_ring_in_if
  import keccak_block_ring_in_pkg::*;
#(
  parameter int WORD_W  = IN_BUF_SIZE,
  parameter int BLOCK_W = KECCAK_RATE,
  parameter int DEPTH   = 2
);
  localparam int WORDS = BLOCK_W / WORD_W;
  localparam int NW_W  = $clog2(WORDS + 1);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WORD_W-1:0]  in_word;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic [BLOCK_W-1:0] out_block;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic [NW_W-1:0]    out_words;
  logic [OCC_W-1:0]   occupancy;

  modport master (
    output in_word, in_valid, in_last, out_ready,
    input  in_ready, out_block, out_valid, out_last, out_words, occupancy
  );

  modport slave (
    input  in_word, in_valid, in_last, out_ready,
    output in_ready, out_block, out_valid, out_last, out_words, occupancy
  );

endinterface

`default_nettype wire

// File: rtl/keccak_block_ring_in_assembler.sv
//------------------------------------------------------------------------------
// Module  : keccak_block_assembler
// Brief   : Packs words MSB-first into a block, closing on a full block or last.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module keccak_block_assembler
  import keccak_block_ring_in_pkg::*;
#(
  parameter int WORD_W  = IN_BUF_SIZE,
  parameter int BLOCK_W = KECCAK_RATE
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [WORD_W-1:0]                    word_i,
  input  logic                                 accept_i,
  input  logic                                 last_i,
  output logic [BLOCK_W-1:0]                   block_o,
  output logic                                 close_o,
  output logic                                 last_o,
  output logic [$clog2(BLOCK_W/WORD_W+1)-1:0]  words_o
);
  localparam int WORDS = BLOCK_W / WORD_W;
  localparam int CNT_W = cnt_w(WORDS);
  localparam int NW_W  = $clog2(WORDS + 1);

  logic [CNT_W-1:0]   wcnt_q, wcnt_d;
  logic [BLOCK_W-1:0] acc_q, acc_d;
  logic [BLOCK_W-1:0] blk_w;

  // acc_q is cleared on every close, so bits below the newest word are zero.
  always_comb begin
    blk_w   = acc_q | ((BLOCK_W'(word_i) << (BLOCK_W - WORD_W)) >> (int'(wcnt_q) * WORD_W));
    close_o = accept_i && (last_i || (wcnt_q == CNT_W'(WORDS - 1)));
    wcnt_d  = wcnt_q;
    acc_d   = acc_q;
    if (accept_i) begin
      if (close_o) begin
        wcnt_d = '0;
        acc_d  = '0;
      end else begin
        wcnt_d = wcnt_q + CNT_W'(1);
        acc_d  = blk_w;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt_q <= '0;
      acc_q  <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      acc_q  <= acc_d;
    end
  end

  assign block_o = blk_w;
  assign last_o  = last_i;
  assign words_o = NW_W'(wcnt_q) + NW_W'(1);

endmodule

`default_nettype wire

// File: rtl/keccak_block_ring_in.sv
//------------------------------------------------------------------------------
// Module  : keccak_block_ring_in
// Brief   : DEPTH-slot ring of assembled rate blocks feeding the permutation.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module keccak_block_ring_in
  import keccak_block_ring_in_pkg::*;
#(
  parameter int WORD_W  = IN_BUF_SIZE,
  parameter int BLOCK_W = KECCAK_RATE,
  parameter int DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  keccak_block_ring_in_if.slave  bus
);
  localparam int WORDS = BLOCK_W / WORD_W;
  localparam int NW_W  = $clog2(WORDS + 1);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = cnt_w(DEPTH);

  logic [BLOCK_W-1:0] blk_q   [DEPTH];
  logic               last_q  [DEPTH];
  logic [NW_W-1:0]    words_q [DEPTH];
  slot_state_e        st_q    [DEPTH];
  slot_state_e        st_d    [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;

  logic               in_ready_w, out_valid_w, accept_w, consume_w;
  logic               close_w, close_last_w;
  logic [BLOCK_W-1:0] close_blk_w;
  logic [NW_W-1:0]    close_words_w;

  // Ready comes only from registered occupancy; no path from out_ready.
  assign in_ready_w  = (occ_q != OCC_W'(DEPTH));
  assign out_valid_w = (st_q[rd_ptr_q] == SLOT_FULL);
  assign accept_w    = bus.in_valid && in_ready_w;
  assign consume_w   = out_valid_w && bus.out_ready;

  keccak_block_assembler #(
    .WORD_W  (WORD_W),
    .BLOCK_W (BLOCK_W)
  ) u_asm (
    .clk      (clk),
    .reset    (reset),
    .word_i   (bus.in_word),
    .accept_i (accept_w),
    .last_i   (bus.in_last),
    .block_o  (close_blk_w),
    .close_o  (close_w),
    .last_o   (close_last_w),
    .words_o  (close_words_w)
  );

  // A full ring blocks closes and an empty ring blocks consumes, so the two
  // pointers never hit the same slot on one edge.
  always_comb begin
    st_d     = st_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (close_w && (wr_ptr_q == PTR_W'(i)))
        st_d[i] = SLOT_FULL;
      if (consume_w && (rd_ptr_q == PTR_W'(i)))
        st_d[i] = SLOT_EMPTY;
    end
    if (close_w)
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (consume_w)
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({close_w, consume_w})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]    <= SLOT_EMPTY;
        blk_q[i]   <= '0;
        last_q[i]  <= 1'b0;
        words_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i] <= st_d[i];
        if (close_w && (wr_ptr_q == PTR_W'(i))) begin
          blk_q[i]   <= close_blk_w;
          last_q[i]  <= close_last_w;
          words_q[i] <= close_words_w;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_block = blk_q[rd_ptr_q];
  assign bus.out_last  = last_q[rd_ptr_q];
  assign bus.out_words = words_q[rd_ptr_q];
  assign bus.occupancy = occ_q;

endmodule

`default_nettype wire
